// File: rtl/ram8.sv
// Hack RAM8: eight 16-bit words built from bit cells, a dmux write
// decode tree and a mux read select tree. Read is combinational.
module dmux (
   input  logic in,
   input  logic sel,
   output logic a,
   output logic b
);
   assign a = in & ~sel;
   assign b = in & sel;
endmodule

module mux #(
   parameter int WIDTH = 16
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             sel,
   output logic [WIDTH-1:0] out
);
   assign out = sel ? b : a;
endmodule

module dmux8way (
   input  logic       in,
   input  logic [2:0] sel,
   output logic [7:0] out
);
   logic [1:0] l1;
   logic [3:0] l2;

   dmux u_d0 (.in(in), .sel(sel[2]), .a(l1[0]), .b(l1[1]));

   for (genvar i = 0; i < 2; i++) begin : g_l2
      dmux u_d (
         .in (l1[i]),
         .sel(sel[1]),
         .a  (l2[2*i]),
         .b  (l2[2*i+1])
      );
   end

   for (genvar i = 0; i < 4; i++) begin : g_l3
      dmux u_d (
         .in (l2[i]),
         .sel(sel[0]),
         .a  (out[2*i]),
         .b  (out[2*i+1])
      );
   end
endmodule

module mux8way16 #(
   parameter int WIDTH = 16
) (
   input  logic [WIDTH-1:0] word [8],
   input  logic [2:0]       sel,
   output logic [WIDTH-1:0] out
);
   logic [WIDTH-1:0] l1 [4];
   logic [WIDTH-1:0] l2 [2];

   for (genvar i = 0; i < 4; i++) begin : g_l1
      mux #(.WIDTH(WIDTH)) u_m (
         .a  (word[2*i]),
         .b  (word[2*i+1]),
         .sel(sel[0]),
         .out(l1[i])
      );
   end

   for (genvar i = 0; i < 2; i++) begin : g_l2
      mux #(.WIDTH(WIDTH)) u_m (
         .a  (l1[2*i]),
         .b  (l1[2*i+1]),
         .sel(sel[1]),
         .out(l2[i])
      );
   end

   mux #(.WIDTH(WIDTH)) u_m3 (
      .a  (l2[0]),
      .b  (l2[1]),
      .sel(sel[2]),
      .out(out)
   );
endmodule

module bit_cell (
   input  logic clk,
   input  logic rst_n,
   input  logic in,
   input  logic load,
   output logic out
);
   logic q;

   always_ff @(posedge clk) begin
      if (!rst_n) q <= 1'b0;
      else        q <= load ? in : q;
   end

   assign out = q;
endmodule

module word_reg #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] in,
   input  logic             load,
   output logic [WIDTH-1:0] out
);
   for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      bit_cell u_bit (
         .clk  (clk),
         .rst_n(rst_n),
         .in   (in[i]),
         .load (load),
         .out  (out[i])
      );
   end
endmodule

module ram8 #(
   parameter int WIDTH  = 16,
   parameter int ADDR_W = 3
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [WIDTH-1:0]  in,
   input  logic              load,
   input  logic [ADDR_W-1:0] address,
   output logic [WIDTH-1:0]  out
);
   logic [7:0]       word_load;
   logic [WIDTH-1:0] mem [8];

   dmux8way u_dec (
      .in (load),
      .sel(address),
      .out(word_load)
   );

   for (genvar w = 0; w < 8; w++) begin : g_word
      word_reg #(.WIDTH(WIDTH)) u_reg (
         .clk  (clk),
         .rst_n(rst_n),
         .in   (in),
         .load (word_load[w]),
         .out  (mem[w])
      );
   end

   mux8way16 #(.WIDTH(WIDTH)) u_sel (
      .word(mem),
      .sel (address),
      .out (out)
   );
endmodule

// File: tb/tb_ram8.sv
// Directed self-checking bench for ram8: reset, writes, same-cycle
// read/write ordering, hold, reset override and edge addresses.
module tb_ram8;
   logic        clk;
   logic        rst_n;
   logic [15:0] in;
   logic        load;
   logic [2:0]  address;
   logic [15:0] out;

   int n_tests;
   int n_fail;

   ram8 dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .in     (in),
      .load   (load),
      .address(address),
      .out    (out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      logic [15:0] exp;
      rst_n = 1'b0;
      load  = 1'b0;
      tick();
      rst_n = 1'b1;
      exp   = 16'h0000;
      for (int a = 0; a < 8; a++) begin
         address = 3'(a);
         #1;
         n_tests++;
         if (out !== exp) begin
            n_fail++;
            $display("FAIL reset_a%0d: got %h want %h", a, out, exp);
         end
      end
   endtask

   task automatic test_fill();
      logic [15:0] exp;
      for (int a = 0; a < 8; a++) begin
         address = 3'(a);
         in      = (a == 7) ? 16'hFFFF : 16'(16'h1111 * (a + 1));
         load    = 1'b1;
         tick();
      end
      load = 1'b0;
      for (int a = 0; a < 8; a++) begin
         address = 3'(a);
         exp     = (a == 7) ? 16'hFFFF : 16'(16'h1111 * (a + 1));
         #1;
         n_tests++;
         if (out !== exp) begin
            n_fail++;
            $display("FAIL fill_a%0d: got %h want %h", a, out, exp);
         end
      end
   endtask

   task automatic test_same_cycle();
      address = 3'd3;
      in      = 16'hABCD;
      load    = 1'b1;
      #1;
      n_tests++;
      if (out !== 16'h4444) begin
         n_fail++;
         $display("FAIL rw_old: got %h want 4444", out);
      end
      tick();
      load = 1'b0;
      n_tests++;
      if (out !== 16'hABCD) begin
         n_fail++;
         $display("FAIL rw_new: got %h want abcd", out);
      end
      address = 3'd4;
      #1;
      n_tests++;
      if (out !== 16'h5555) begin
         n_fail++;
         $display("FAIL rw_neigh: got %h want 5555", out);
      end
   endtask

   task automatic test_hold();
      load    = 1'b0;
      in      = 16'hDEAD;
      address = 3'd5;
      for (int i = 0; i < 3; i++) begin
         tick();
         n_tests++;
         if (out !== 16'h6666) begin
            n_fail++;
            $display("FAIL hold_%0d: got %h want 6666", i, out);
         end
      end
      address = 3'd2;
      #1;
      n_tests++;
      if (out !== 16'h3333) begin
         n_fail++;
         $display("FAIL comb_read: got %h want 3333", out);
      end
   endtask

   task automatic test_reset_override();
      rst_n   = 1'b0;
      load    = 1'b1;
      address = 3'd0;
      in      = 16'h1234;
      tick();
      rst_n = 1'b1;
      load  = 1'b0;
      for (int a = 0; a < 8; a++) begin
         address = 3'(a);
         #1;
         n_tests++;
         if (out !== 16'h0000) begin
            n_fail++;
            $display("FAIL rst_ovr_a%0d: got %h want 0000", a, out);
         end
      end
   endtask

   task automatic test_back_to_back();
      rst_n   = 1'b1;
      load    = 1'b1;
      address = 3'd7;
      in      = 16'h8001;
      tick();
      address = 3'd0;
      in      = 16'h0001;
      tick();
      load    = 1'b0;
      address = 3'd7;
      #1;
      n_tests++;
      if (out !== 16'h8001) begin
         n_fail++;
         $display("FAIL b2b_a7: got %h want 8001", out);
      end
      address = 3'd0;
      #1;
      n_tests++;
      if (out !== 16'h0001) begin
         n_fail++;
         $display("FAIL b2b_a0: got %h want 0001", out);
      end
      address = 3'd1;
      #1;
      n_tests++;
      if (out !== 16'h0000) begin
         n_fail++;
         $display("FAIL b2b_a1: got %h want 0000", out);
      end
   endtask

   initial begin
      n_tests = 0;
      n_fail  = 0;
      rst_n   = 1'b0;
      load    = 1'b0;
      in      = 16'h0000;
      address = 3'd0;
      #2;
      test_reset();
      test_fill();
      test_same_cycle();
      test_hold();
      test_reset_override();
      test_back_to_back();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/ram8.md
Name: ram8

Overview:
- 8-word × 16-bit register-file memory, Hack "RAM8".
- It is the first sequential consumer of the existing gate library. The dmux tree decodes the write enable to one word register. The mux tree selects the read word.
- It sits downstream of the combinational gates and upstream of the larger RAM (RAM64 and up) and the data path.
- Read is combinational. Write is clocked.

Parameters:
- WIDTH, 16, data word width in bits; the Hack configuration fixes it at 16.
- ADDR_W, 3, address width. Depth is 2**ADDR_W = 8. Only 3 is supported.

Ports:
- clk  in  1  system clock. All state updates on the rising edge.
- rst_n  in  1  synchronous active-low reset, sampled on the rising edge of clk.
- in  in  WIDTH  write data.
- load  in  1  write enable.
- address  in  ADDR_W  word select, used for both read and write.
- out  out  WIDTH  read data, always mem[address].

Behaviour:
- Storage: 8 registers, each WIDTH bits. Each register is a `register` of WIDTH `bit` cells. A bit cell is a DFF with a mux feedback: `bit_next = load_i ? in_i : bit_q`.
- Write decode: a dmux8way built from the existing dmux produces load_0..load_7 from load and address. Exactly one load_i equals load; all others are 0.
- Read select: a mux8way16 built from the existing mux drives out from mem[address]. The path is purely combinational, with zero-cycle latency from an address change.
- Rising edge with rst_n=0: all 8 words become 0, regardless of load, address and in.
- Rising edge with rst_n=1 and load=1: mem[address] <= in. All other words hold.
- Rising edge with rst_n=1 and load=0: all words hold.
- Reset value of out: 0 for every address from the first edge after rst_n=0 is sampled. Before the first reset, out is X.
- Write/read same address, same cycle: out shows the old value until the edge. From the edge onward it shows the new value. There is no write-through bypass before the edge.
- Write to A while reading B ≠ A: out is unaffected by the write.
- Address wrap: address is exactly 3 bits, so there is no out-of-range case. Addresses 7 and 0 are independent words.
- Reset mid-operation: rst_n=0 overrides load=1 on the same edge. The write is discarded and the word becomes 0.
- Back-to-back writes: one write per cycle to any address sequence is allowed. No stalls and no handshake.
- out depends only on stored state and address. It never depends on in or load combinationally.

Test Plan:
1. Hold rst_n=0 for 1 edge, then rst_n=1 with load=0. Sweep address 0..7, #1 each. Required: out=16'h0000 at every address.
2. Write mem[a]=16'h1111*(a+1) for a=0..6, and mem[7]=16'hFFFF, one per edge. Then read a=0..7 with load=0. Required: out=16'h1111, 16'h2222, …, 16'h7777, 16'hFFFF. No aliasing between words.
3. Set address=3, in=16'hABCD, load=1.
   - Before the edge: out=16'h4444 (old value).
   - After the edge: out=16'hABCD.
   - Then set address=4: out=16'h5555, so the neighbour is untouched.
4. Set load=0, in=16'hDEAD, address=5, and apply 3 edges. Required: out stays 16'h6666. Then switch address 5→2 with no edge. Required: out changes to 16'h3333 within #1 (combinational read).
5. Set rst_n=0, load=1, address=0, in=16'h1234, and apply 1 edge. Required: every address reads 16'h0000. The write is discarded.
6. Set rst_n=1 and write 16'h8001 to address 7, then 16'h0001 to address 0 on consecutive edges. Required: out=16'h8001 at address 7 and out=16'h0001 at address 0, confirming the MSB/LSB and edge addresses are independent.
